// File: rtl/dec_adder_2d.sv
// dec_adder_2d: two-digit packed-BCD adder with registered sum, carry, valid and illegal-digit flag
module dec_adder_2d (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] A1,
  input  logic [3:0] A0,
  input  logic [3:0] B1,
  input  logic [3:0] B0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       c_out,
  output logic       out_valid,
  output logic       err
);
  logic [4:0] t0, t1;
  logic       c0, c1, bad;
  logic [3:0] s1_d, s0_d, s1_q, s0_q;
  logic       c_d, err_d, c_q, err_q, v_q;
  // per-digit decimal add with +6 correction; illegal digits force a zero result and raise err
  always_comb begin
    t0 = {1'b0, A0} + {1'b0, B0};
    c0 = t0 > 5'd9;
    t1 = {1'b0, A1} + {1'b0, B1} + {4'd0, c0};
    c1 = t1 > 5'd9;
    bad = (A1 > 4'd9) | (A0 > 4'd9) | (B1 > 4'd9) | (B0 > 4'd9);
    s0_d = bad ? 4'd0 : c0 ? t0[3:0] + 4'd6 : t0[3:0];
    s1_d = bad ? 4'd0 : c1 ? t1[3:0] + 4'd6 : t1[3:0];
    c_d = ~bad & c1;
    err_d = bad;
  end
  // capture on in_valid, hold otherwise; out_valid follows in_valid by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 4'd0;
      s0_q <= 4'd0;
      c_q <= 1'b0;
      err_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
        s0_q <= s0_d;
        c_q <= c_d;
        err_q <= err_d;
      end
    end
  end
  assign s1 = s1_q;
  assign s0 = s0_q;
  assign c_out = c_q;
  assign err = err_q;
  assign out_valid = v_q;
endmodule

// File: tb/tb_dec_adder_2d.sv
// tb_dec_adder_2d: randomized and directed checks of dec_adder_2d against a decimal reference model
module tb_dec_adder_2d;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [3:0] A1 = 4'd0, A0 = 4'd0, B1 = 4'd0, B0 = 4'd0;
  logic [3:0] s1, s0;
  logic c_out, out_valid, err;
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] e_s1 = 4'd0, e_s0 = 4'd0;
  logic e_c = 1'b0, e_v = 1'b0, e_err = 1'b0;

  dec_adder_2d dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A1(A1), .A0(A0), .B1(B1), .B0(B0),
    .s1(s1), .s0(s0), .c_out(c_out), .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  // reference: whole-number decimal addition, result split back into digits
  function automatic logic [9:0] ref_sum(input int a1, input int a0, input int b1, input int b0);
    int sum;
    if (a1 > 9 || a0 > 9 || b1 > 9 || b0 > 9) return {4'd0, 4'd0, 1'b0, 1'b1};
    sum = (a1 * 10 + a0) + (b1 * 10 + b0);
    return {4'((sum / 10) % 10), 4'(sum % 10), sum >= 100, 1'b0};
  endfunction

  // drive one cycle of inputs, advance past the edge, update expected outputs
  task automatic drive(input logic v, input logic [3:0] a1, input logic [3:0] a0,
                       input logic [3:0] b1, input logic [3:0] b0);
    logic [9:0] r;
    in_valid = v; A1 = a1; A0 = a0; B1 = b1; B0 = b0;
    @(posedge clk);
    #1;
    if (rst) begin
      {e_s1, e_s0, e_c, e_err} = 10'd0;
      e_v = 1'b0;
    end else begin
      e_v = v;
      if (v) begin
        r = ref_sum(a1, a0, b1, b0);
        {e_s1, e_s0, e_c, e_err} = r;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
    drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    vectors++;
    if ({s1, s0, c_out, out_valid, err} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset: got s1=%0d s0=%0d c=%0d v=%0d err=%0d, expected all 0", s1, s0, c_out, out_valid, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] cases [7] = '{16'h0305, 16'h0605, 16'h2426, 16'h4951, 16'h9999, 16'hA000, 16'h0101};
    logic [15:0] c;
    for (int i = 0; i < 7; i++) begin
      c = cases[i];
      drive(1'b1, c[15:12], c[11:8], c[7:4], c[3:0]);
      vectors++;
      if ({s1, s0, c_out, out_valid, err} !== {e_s1, e_s0, e_c, e_v, e_err}) begin
        miscompares++;
        $display("FAIL directed %h: got s1=%0d s0=%0d c=%0d v=%0d err=%0d, expected s1=%0d s0=%0d c=%0d v=%0d err=%0d",
                 c, s1, s0, c_out, out_valid, err, e_s1, e_s0, e_c, e_v, e_err);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd7, 4'd8, 4'd4, 4'd5);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      vectors++;
      if ({s1, s0, c_out, out_valid, err} !== {4'd2, 4'd3, 1'b1, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL hold: got s1=%0d s0=%0d c=%0d v=%0d err=%0d, expected s1=2 s0=3 c=1 v=0 err=0",
                 s1, s0, c_out, out_valid, err);
      end
    end
  endtask

  task automatic test_rst_priority();
    drive(1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
    rst = 1'b1;
    drive(1'b1, 4'd5, 4'd5, 4'd5, 4'd5);
    rst = 1'b0;
    vectors++;
    if ({s1, s0, c_out, out_valid, err} !== 11'd0) begin
      miscompares++;
      $display("FAIL rst_priority: got s1=%0d s0=%0d c=%0d v=%0d err=%0d, expected all 0", s1, s0, c_out, out_valid, err);
    end
  endtask

  task automatic test_exhaustive();
    for (int a = 0; a < 100; a++)
      for (int b = 0; b < 100; b++) begin
        drive(1'b1, 4'(a / 10), 4'(a % 10), 4'(b / 10), 4'(b % 10));
        vectors++;
        if ({s1, s0, c_out, out_valid, err} !== {e_s1, e_s0, e_c, e_v, e_err}) begin
          miscompares++;
          $display("FAIL sweep %0d+%0d: got s1=%0d s0=%0d c=%0d v=%0d err=%0d, expected s1=%0d s0=%0d c=%0d v=%0d err=%0d",
                   a, b, s1, s0, c_out, out_valid, err, e_s1, e_s0, e_c, e_v, e_err);
        end
      end
  endtask

  task automatic test_random();
    logic [3:0] d [4];
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) d[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      drive(1'($urandom_range(0, 3) != 0), d[0], d[1], d[2], d[3]);
      vectors++;
      if ({s1, s0, c_out, out_valid, err} !== {e_s1, e_s0, e_c, e_v, e_err}) begin
        miscompares++;
        $display("FAIL random %0d: got s1=%0d s0=%0d c=%0d v=%0d err=%0d, expected s1=%0d s0=%0d c=%0d v=%0d err=%0d",
                 i, s1, s0, c_out, out_valid, err, e_s1, e_s0, e_c, e_v, e_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_rst_priority();
    test_exhaustive();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
